counter_updown_mod_prescale: RTL and testbench
==============================================

// Module: counter_updown_mod_prescale
// PURPOSE
//   Parametrised up/down modulo counter, successor to the 8-bit T-flip-flop counter.
//   Adds: configurable width/modulus, direction control, parallel load, clock-enable
//   prescaler, wrap-vs-saturate mode, terminal-count and wrap flags.
//   General-purpose timebase/event counter for lab datapaths; one clock, async clear.
// PARAMETERS
//   WIDTH     8    counter width in bits (1..32)
//   MODULUS   256  count range 0..MODULUS-1; legal 2..2**WIDTH
//   PRESCALE  1    enabled clocks per count step (1 = step every enabled clock; legal 1..65536)
// PORTS
//   Clock          in   1      rising-edge clock
//   Clear_n        in   1      asynchronous active-low reset
//   Enable         in   1      count enable; gates prescaler and counter
//   Up             in   1      1 = count up, 0 = count down; sampled on the step cycle
//   Saturate       in   1      1 = hold at limit, 0 = wrap around
//   Load           in   1      synchronous parallel load, highest synchronous priority
//   Load_Value     in   WIDTH  value loaded when Load=1
//   Q              out  WIDTH  counter value (registered)
//   Terminal_Count out  1      combinational: Up ? (Q==MODULUS-1) : (Q==0)
//   Wrap           out  1      registered one-cycle pulse, high the cycle after a wrap step
// BEHAVIOUR
//   Reset (Clear_n=0, async, any time): Q=0, prescaler count=0, Wrap=0 immediately;
//     held while Clear_n=0; first update on first rising edge after release.
//   Priority per edge: Clear_n > Load > Enable > hold.
//   Load=1: Q <= min(Load_Value, MODULUS-1); prescaler count <= 0; Wrap <= 0;
//     Enable ignored that cycle. Load_Value >= MODULUS clamps to MODULUS-1.
//   Prescaler: internal count p in 0..PRESCALE-1, width clog2(PRESCALE) (min 1).
//     Enable=1, Load=0: step = (p==PRESCALE-1); p <= step ? 0 : p+1.
//     Enable=0: p and Q hold; Wrap <= 0. PRESCALE=1: step every enabled clock.
//   Step, Up=1: Q<MODULUS-1 -> Q+1; Q==MODULUS-1 -> 0 with Wrap<=1 (Saturate=0),
//     or hold with Wrap<=0 (Saturate=1).
//   Step, Up=0: Q>0 -> Q-1; Q==0 -> MODULUS-1 with Wrap<=1 (Saturate=0),
//     or hold with Wrap<=0 (Saturate=1).
//   Non-step cycles: Q holds, Wrap <= 0. Wrap is never high two consecutive cycles
//     unless consecutive steps both wrap (MODULUS=2 or PRESCALE=1 boundary cases allowed).
//   Arithmetic: compare/increment in WIDTH+1 bits so MODULUS=2**WIDTH is exact;
//     Q never leaves 0..MODULUS-1 for any input sequence.
//   Up/Saturate changes mid-prescale take effect at the next step; no glitch on Q.
//   Terminal_Count follows Q and Up combinationally; 0 only depends on those two.
//   Load asserted together with a would-be step: load wins, no step, no Wrap.
// TESTING
//   T1 reset: Clear_n=0 mid-count (Q=0x37, Wrap=1) -> Q=0, Wrap=0 before next edge;
//      release, Enable=1, Up=1, PRESCALE=1 -> Q=1,2,3 on successive edges.
//   T2 wrap up: WIDTH=8, MODULUS=10, Load 9, Up=1, Enable=1 -> TC=1; next edge Q=0,
//      Wrap=1 for exactly one cycle, then Q=1, Wrap=0.
//   T3 wrap down/saturate: MODULUS=10, Q=0, Up=0: Saturate=0 -> Q=9 + Wrap pulse;
//      Saturate=1 -> Q stays 0 for 5 edges, Wrap stays 0, TC=1.
//   T4 prescaler: PRESCALE=4, Enable=1 from Q=0 -> Q=1 after 4 edges, 2 after 8;
//      Enable=0 for 3 edges mid-period -> period stretches by exactly 3 edges.
//   T5 load priority/clamp: MODULUS=10, Load=1 with Enable=1, Load_Value=200 -> Q=9,
//      no step, Wrap=0, prescaler restarts (next step after PRESCALE enabled edges).
//   T6 full range: WIDTH=8, MODULUS=256, Up=1 from 255 -> Q=0, Wrap=1; 512-step
//      random Up/Enable run vs. reference model, Q always in 0..255.

Source files
------------

// File: rtl/counter_updown_mod_prescale_if.sv
// Control and status bundle for the up/down modulo counter.
// The counter owns q/terminal_count/wrap; everything else is driven by its user.
interface counter_updown_mod_prescale_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             up;
  logic             saturate;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] q;
  logic             terminal_count;
  logic             wrap;

  modport master (
    output enable, up, saturate, load, load_value,
    input  q, terminal_count, wrap
  );

  modport slave (
    input  enable, up, saturate, load, load_value,
    output q, terminal_count, wrap
  );
endinterface

// File: rtl/counter_updown_mod_prescale.sv
// Up/down modulo counter with a clock-enable prescaler, parallel load,
// wrap-or-saturate limit handling, terminal-count and one-cycle wrap flags.
module counter_updown_mod_prescale #(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter int     PRESCALE = 1
) (
  input  logic                          i_clock,
  input  logic                          i_clear_n,
  counter_updown_mod_prescale_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  // Limit held one bit wider so MODULUS == 2**WIDTH is represented exactly.
  localparam logic [WIDTH:0] MOD_M1 = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [PW-1:0]  P_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] r_q;
  logic [PW-1:0]    r_p;
  logic             r_wrap;

  logic [WIDTH-1:0] w_q_next;
  logic [PW-1:0]    w_p_next;
  logic             w_wrap_next;
  logic             w_step;
  logic             w_at_top;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_load_clamped;

  assign w_step    = (r_p == P_LAST);
  assign w_at_top  = ({1'b0, r_q} == MOD_M1);
  assign w_at_zero = (r_q == '0);

  assign w_load_clamped = ({1'b0, bus.load_value} > MOD_M1) ? MOD_M1[WIDTH-1:0]
                                                            : bus.load_value;

  always_comb begin
    w_q_next    = r_q;
    w_p_next    = r_p;
    w_wrap_next = 1'b0;
    if (bus.load) begin
      w_q_next = w_load_clamped;
      w_p_next = '0;
    end else if (bus.enable) begin
      w_p_next = w_step ? '0 : r_p + PW'(1);
      if (w_step) begin
        if (bus.up) begin
          if (!w_at_top) begin
            w_q_next = r_q + WIDTH'(1);
          end else if (!bus.saturate) begin
            w_q_next    = '0;
            w_wrap_next = 1'b1;
          end
        end else begin
          if (!w_at_zero) begin
            w_q_next = r_q - WIDTH'(1);
          end else if (!bus.saturate) begin
            w_q_next    = MOD_M1[WIDTH-1:0];
            w_wrap_next = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_q    <= '0;
      r_p    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_p    <= w_p_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bus.q              = r_q;
  assign bus.wrap           = r_wrap;
  assign bus.terminal_count = bus.up ? w_at_top : w_at_zero;

endmodule

// File: tb/tb_counter_updown_mod_prescale.sv
// Bench for counter_updown_mod_prescale: three instances (mod 10, mod 10 /4, mod 256)
// share one stimulus stream; a behavioural model predicts each cycle's outputs.
module tb_counter_updown_mod_prescale;

  logic clk = 1'b0;
  logic clear_n = 1'b0;

  logic       s_en = 1'b0;
  logic       s_up = 1'b0;
  logic       s_sat = 1'b0;
  logic       s_ld = 1'b0;
  logic [7:0] s_lv = '0;

  int n_vec = 0;
  int n_err = 0;

  // Per-instance expected entry: {tc, wrap, q[7:0]}, three instances packed.
  logic [29:0] exp_q[$];
  logic [29:0] mon_e;

  int mod_a[3] = '{10, 10, 256};
  int pre_a[3] = '{1, 4, 1};
  int m_q[3];
  int m_p[3];
  int m_w[3];

  logic [9:0] obs[3];

  counter_updown_mod_prescale_if #(.WIDTH(8)) if_a ();
  counter_updown_mod_prescale_if #(.WIDTH(8)) if_b ();
  counter_updown_mod_prescale_if #(.WIDTH(8)) if_c ();

  assign if_a.enable = s_en;  assign if_a.up = s_up;  assign if_a.saturate = s_sat;
  assign if_a.load = s_ld;    assign if_a.load_value = s_lv;
  assign if_b.enable = s_en;  assign if_b.up = s_up;  assign if_b.saturate = s_sat;
  assign if_b.load = s_ld;    assign if_b.load_value = s_lv;
  assign if_c.enable = s_en;  assign if_c.up = s_up;  assign if_c.saturate = s_sat;
  assign if_c.load = s_ld;    assign if_c.load_value = s_lv;

  assign obs[0] = {if_a.terminal_count, if_a.wrap, if_a.q};
  assign obs[1] = {if_b.terminal_count, if_b.wrap, if_b.q};
  assign obs[2] = {if_c.terminal_count, if_c.wrap, if_c.q};

  counter_updown_mod_prescale #(.WIDTH(8), .MODULUS(10), .PRESCALE(1)) dut_a (
    .i_clock(clk), .i_clear_n(clear_n), .bus(if_a.slave));
  counter_updown_mod_prescale #(.WIDTH(8), .MODULUS(10), .PRESCALE(4)) dut_b (
    .i_clock(clk), .i_clear_n(clear_n), .bus(if_b.slave));
  counter_updown_mod_prescale #(.WIDTH(8), .MODULUS(256), .PRESCALE(1)) dut_c (
    .i_clock(clk), .i_clear_n(clear_n), .bus(if_c.slave));

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_q[k] = 0; m_p[k] = 0; m_w[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic en, input logic up, input logic sat,
                            input logic ld, input logic [7:0] lv);
    int top;
    top = mod_a[k] - 1;
    m_w[k] = 0;
    if (ld) begin
      m_q[k] = (int'(lv) > top) ? top : int'(lv);
      m_p[k] = 0;
    end else if (en) begin
      if (m_p[k] == pre_a[k] - 1) begin
        m_p[k] = 0;
        if (up) begin
          if (m_q[k] != top) m_q[k] = m_q[k] + 1;
          else if (!sat) begin m_q[k] = 0; m_w[k] = 1; end
        end else begin
          if (m_q[k] != 0) m_q[k] = m_q[k] - 1;
          else if (!sat) begin m_q[k] = top; m_w[k] = 1; end
        end
      end else begin
        m_p[k] = m_p[k] + 1;
      end
    end
  endtask

  // driver: apply one cycle of stimulus and queue the predicted outputs
  task automatic drive(input logic en, input logic up, input logic sat,
                       input logic ld, input logic [7:0] lv);
    logic [29:0] e;
    logic        tc;
    @(negedge clk);
    s_en = en; s_up = up; s_sat = sat; s_ld = ld; s_lv = lv;
    for (int k = 0; k < 3; k++) begin
      model_step(k, en, up, sat, ld, lv);
      tc = up ? (m_q[k] == mod_a[k] - 1) : (m_q[k] == 0);
      e[k*10 +: 10] = {tc, m_w[k][0], 8'(m_q[k])};
    end
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    s_en = 1'b0; s_up = 1'b0; s_sat = 1'b0; s_ld = 1'b0; s_lv = '0;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // scoreboard: compare every instance after each active edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        check($sformatf("q%0d", k),    32'(obs[k][7:0]), 32'(mon_e[k*10 +: 8]));
        check($sformatf("wrap%0d", k), 32'(obs[k][8]),   32'(mon_e[k*10 + 8]));
        check($sformatf("tc%0d", k),   32'(obs[k][9]),   32'(mon_e[k*10 + 9]));
      end
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("rst_q_a", 32'(if_a.q), 0);
    check("rst_q_c", 32'(if_c.q), 0);
    check("rst_wrap_a", 32'(if_a.wrap), 0);
    check("rst_tc_a", 32'(if_a.terminal_count), 1);
    @(negedge clk);
    clear_n = 1'b1;

    // async clear mid-count with a live wrap pulse
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h36);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    settle();
    check("t1_pre_q_c", 32'(if_c.q), 32'h37);
    check("t1_pre_wrap_a", 32'(if_a.wrap), 1);
    idle_inputs();
    #1;
    clear_n = 1'b0;
    #1;
    check("t1_clr_q_c", 32'(if_c.q), 0);
    check("t1_clr_wrap_a", 32'(if_a.wrap), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      settle();
      check($sformatf("t1_count%0d", i), 32'(if_c.q), 32'(i));
    end

    // wrap up at MODULUS-1
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'd9);
    settle();
    check("t2_tc", 32'(if_a.terminal_count), 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    settle();
    check("t2_wrap_q", 32'(if_a.q), 0);
    check("t2_wrap_pulse", 32'(if_a.wrap), 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    settle();
    check("t2_after_q", 32'(if_a.q), 1);
    check("t2_after_wrap", 32'(if_a.wrap), 0);

    // wrap down, then saturate at zero
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    settle();
    check("t3_down_q", 32'(if_a.q), 9);
    check("t3_down_wrap", 32'(if_a.wrap), 1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      settle();
      check("t3_sat_q", 32'(if_a.q), 0);
      check("t3_sat_tc", 32'(if_a.terminal_count), 1);
    end

    // prescale by 4 on dut_b, with a 3-edge enable gap
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
    repeat (4) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    settle();
    check("t4_q1", 32'(if_b.q), 1);
    repeat (4) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    settle();
    check("t4_q2", 32'(if_b.q), 2);
    repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (1) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    settle();
    check("t4_stretch_hold", 32'(if_b.q), 2);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    settle();
    check("t4_stretch_q3", 32'(if_b.q), 3);

    // load clamp beats a concurrent step and restarts the prescaler
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd200);
    settle();
    check("t5_clamp_a", 32'(if_a.q), 9);
    check("t5_clamp_b", 32'(if_b.q), 9);
    check("t5_load_c", 32'(if_c.q), 200);
    check("t5_wrap_b", 32'(if_b.wrap), 0);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    settle();
    check("t5_prescale_hold", 32'(if_b.q), 9);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    settle();
    check("t5_prescale_step", 32'(if_b.q), 8);

    // full-range wrap then random run
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'd255);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    settle();
    check("t6_wrap_q", 32'(if_c.q), 0);
    check("t6_wrap_pulse", 32'(if_c.wrap), 1);
    for (int i = 0; i < 512; i++) begin
      drive(($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 31) == 0),
            8'($urandom_range(0, 255)));
    end
    settle();
    check("drain_queue", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
